// File: rtl/prv32_bus_arbiter_if.sv
// Bus bundle shared by the two PRV32 bus masters, the arbiter and the single
// slave port (RAM / UART / LED GPIO decode).
// 'slave'  : the arbiter's view. It serves the masters' requests and drives the
//            slave-side cycle.
// 'master' : the view of the surrounding system. It issues the requests and
//            answers on the slave side.
interface prv32_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_we;
    logic [DW-1:0] m0_wdata;
    logic [DW/8-1:0] m0_be;
    logic          m0_ack;
    logic          m0_err;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic          m1_we;
    logic [DW-1:0] m1_wdata;
    logic [DW/8-1:0] m1_be;
    logic          m1_ack;
    logic          m1_err;
    logic [DW-1:0] m1_rdata;

    logic          s_cyc;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [DW-1:0] s_wdata;
    logic [DW/8-1:0] s_be;
    logic          s_ack;
    logic [DW-1:0] s_rdata;

    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata, m0_be,
        input  m1_req, m1_addr, m1_we, m1_wdata, m1_be,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata,
        output s_cyc, s_addr, s_we, s_wdata, s_be,
        input  s_ack, s_rdata
    );

    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata, m0_be,
        output m1_req, m1_addr, m1_we, m1_wdata, m1_be,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata,
        input  s_cyc, s_addr, s_we, s_wdata, s_be,
        output s_ack, s_rdata
    );
endinterface

// File: rtl/prv32_bus_arbiter.sv
// Two-master / single-slave request-ack arbiter for the PRV32 SOPC bus.
// m0 = CPU data port, m1 = UART boot-loader/debug master. One transfer is in
// flight at a time. A watchdog ends transfers the slave never acknowledges
// with an error ack, so a dead peripheral cannot hang either master.
module prv32_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst,
    prv32_bus_arbiter_if.slave  bus,
    output logic                grant,
    output logic [7:0]          tmo_count
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam int              WDW       = $clog2(TIMEOUT + 1);
    // Watchdog value seen in the last BUSY cycle before the timeout fires:
    // BUSY lasts exactly TIMEOUT cycles when the slave stays silent.
    localparam logic [WDW-1:0]  WDOG_LAST = WDW'(TIMEOUT - 1);
    localparam logic [DW-1:0]   ERR_RDATA = DW'(32'hDEAD_BEEF);

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [7:0]      tmo_q, tmo_d;

    logic            any_req;
    logic            winner;
    logic            in_busy;
    logic            in_err;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   wdata_sel;
    logic [DW/8-1:0] be_sel;
    logic            we_sel;

    // Arbitration: a lone requester wins; ties go to m0 (fixed) or away from the last owner.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        winner  = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else if (bus.m1_req) begin
            winner = 1'b1;
        end
    end

    // Next state: bus ownership, watchdog and saturating timeout counter.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        tmo_d        = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_BUSY;
                    grant_d      = winner;
                    last_grant_d = winner;
                    wdog_d       = '0;
                end
            end
            ST_BUSY: begin
                // A slave ack in the final watchdog cycle still completes normally.
                if (bus.s_ack) begin
                    state_d = ST_IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                if (tmo_q != 8'hFF) begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer in flight without acknowledging it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wdog_q       <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            tmo_q        <= tmo_d;
        end
    end

    // Slave-side muxes from the owner, and ack/err/rdata routing back to the masters.
    always_comb begin
        in_busy   = (state_q == ST_BUSY);
        in_err    = (state_q == ST_ERR);

        addr_sel  = grant_q ? bus.m1_addr  : bus.m0_addr;
        wdata_sel = grant_q ? bus.m1_wdata : bus.m0_wdata;
        be_sel    = grant_q ? bus.m1_be    : bus.m0_be;
        we_sel    = grant_q ? bus.m1_we    : bus.m0_we;

        bus.s_cyc   = in_busy;
        bus.s_addr  = addr_sel;
        bus.s_wdata = wdata_sel;
        bus.s_be    = be_sel;
        bus.s_we    = we_sel;

        // Slave acks outside BUSY are dropped; the ERR cycle acks on its own.
        bus.m0_ack  = ((in_busy & bus.s_ack) | in_err) & ~grant_q;
        bus.m1_ack  = ((in_busy & bus.s_ack) | in_err) &  grant_q;
        bus.m0_err  = in_err & ~grant_q;
        bus.m1_err  = in_err &  grant_q;
        bus.m0_rdata = (in_err & ~grant_q) ? ERR_RDATA : bus.s_rdata;
        bus.m1_rdata = (in_err &  grant_q) ? ERR_RDATA : bus.s_rdata;

        grant     = grant_q;
        tmo_count = tmo_q;
    end
endmodule

// File: tb/tb_prv32_bus_arbiter.sv
// Bench for prv32_bus_arbiter: a round-robin instance and a fixed-priority
// instance see identical stimulus; a transaction-level model predicts owner,
// transfer length, ack/err/rdata and the timeout count for both.
`timescale 1ns/1ps
module tb_prv32_bus_arbiter;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we, s_ack;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_be, m1_be;
    logic        grant0, grant1;
    logic [7:0]  tmo0, tmo1;

    int checks   = 0;
    int failures = 0;

    // Model state: last round-robin owner and expected timeout count.
    bit mdl_last;
    int mdl_tmo;

    prv32_bus_arbiter_if #(.AW(32), .DW(32)) bus0 ();
    prv32_bus_arbiter_if #(.AW(32), .DW(32)) bus1 ();

    assign bus0.m0_req = m0_req;     assign bus1.m0_req = m0_req;
    assign bus0.m0_addr = m0_addr;   assign bus1.m0_addr = m0_addr;
    assign bus0.m0_we = m0_we;       assign bus1.m0_we = m0_we;
    assign bus0.m0_wdata = m0_wdata; assign bus1.m0_wdata = m0_wdata;
    assign bus0.m0_be = m0_be;       assign bus1.m0_be = m0_be;
    assign bus0.m1_req = m1_req;     assign bus1.m1_req = m1_req;
    assign bus0.m1_addr = m1_addr;   assign bus1.m1_addr = m1_addr;
    assign bus0.m1_we = m1_we;       assign bus1.m1_we = m1_we;
    assign bus0.m1_wdata = m1_wdata; assign bus1.m1_wdata = m1_wdata;
    assign bus0.m1_be = m1_be;       assign bus1.m1_be = m1_be;
    assign bus0.s_ack = s_ack;       assign bus1.s_ack = s_ack;
    assign bus0.s_rdata = s_rdata;   assign bus1.s_rdata = s_rdata;

    prv32_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst), .bus(bus0), .grant(grant0), .tmo_count(tmo0)
    );
    prv32_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .bus(bus1), .grant(grant1), .tmo_count(tmo1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        s_cyc;
        logic        grant;
        logic        s_we;
        logic        m0_ack;
        logic        m1_ack;
        logic        m0_err;
        logic        m1_err;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_be;
        logic [31:0] m0_rdata;
        logic [31:0] m1_rdata;
        logic [7:0]  tmo;
    } obs_t;

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o.s_cyc = bus0.s_cyc;   o.grant = grant0;       o.s_we = bus0.s_we;
            o.m0_ack = bus0.m0_ack; o.m1_ack = bus0.m1_ack;
            o.m0_err = bus0.m0_err; o.m1_err = bus0.m1_err;
            o.s_addr = bus0.s_addr; o.s_wdata = bus0.s_wdata; o.s_be = bus0.s_be;
            o.m0_rdata = bus0.m0_rdata; o.m1_rdata = bus0.m1_rdata; o.tmo = tmo0;
        end else begin
            o.s_cyc = bus1.s_cyc;   o.grant = grant1;       o.s_we = bus1.s_we;
            o.m0_ack = bus1.m0_ack; o.m1_ack = bus1.m1_ack;
            o.m0_err = bus1.m0_err; o.m1_err = bus1.m1_err;
            o.s_addr = bus1.s_addr; o.s_wdata = bus1.s_wdata; o.s_be = bus1.s_be;
            o.m0_rdata = bus1.m0_rdata; o.m1_rdata = bus1.m1_rdata; o.tmo = tmo1;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic string pfx(input string t, input int d);
        return {t, (d == 0) ? "_rr" : "_fp"};
    endfunction

    // Slave-side forwarding from owner w while a cycle is (or is not) expected.
    task automatic chk_bus(input string t, input int d, input bit w, input bit cyc);
        obs_t o;
        string p;
        o = sample(d);
        p = pfx(t, d);
        chk({p, "_s_cyc"}, 32'(o.s_cyc), 32'(cyc));
        if (cyc) begin
            chk({p, "_grant"}, 32'(o.grant), 32'(w));
            chk({p, "_s_addr"}, o.s_addr, w ? m1_addr : m0_addr);
            chk({p, "_s_wdata"}, o.s_wdata, w ? m1_wdata : m0_wdata);
            chk({p, "_s_be"}, 32'(o.s_be), 32'(w ? m1_be : m0_be));
            chk({p, "_s_we"}, 32'(o.s_we), 32'(w ? m1_we : m0_we));
        end
    endtask

    // Master-side response: owner w gets ack/err/rdw, the other sees rdo and nothing else.
    task automatic chk_resp(input string t, input int d, input bit w, input bit ack,
                            input bit err, input logic [31:0] rdw, input logic [31:0] rdo);
        obs_t o;
        string p;
        o = sample(d);
        p = pfx(t, d);
        chk({p, "_m0_ack"}, 32'(o.m0_ack), 32'(ack && !w));
        chk({p, "_m1_ack"}, 32'(o.m1_ack), 32'(ack && w));
        chk({p, "_m0_err"}, 32'(o.m0_err), 32'(err && !w));
        chk({p, "_m1_err"}, 32'(o.m1_err), 32'(err && w));
        chk({p, "_m0_rdata"}, o.m0_rdata, w ? rdo : rdw);
        chk({p, "_m1_rdata"}, o.m1_rdata, w ? rdw : rdo);
    endtask

    task automatic chk_tmo(input string t, input int d);
        obs_t o;
        o = sample(d);
        chk(pfx({t, "_tmo"}, d), 32'(o.tmo), 32'(mdl_tmo));
    endtask

    task automatic set_m(input int m, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] be);
        if (m == 0) begin
            m0_addr = a; m0_we = we; m0_wdata = wd; m0_be = be;
        end else begin
            m1_addr = a; m1_we = we; m1_wdata = wd; m1_be = be;
        end
    endtask

    // One transaction. Called in the low phase of an IDLE cycle; returns in the
    // low phase of the following IDLE cycle with both requests dropped.
    // ack_after in 1..TMO: slave acks in that BUSY cycle; otherwise it never acks.
    task automatic round(input string t, input bit r0, input bit r1,
                         input int ack_after, input logic [31:0] rd);
        bit w[2];
        bit tmo_hit;
        int n;
        w[0]    = (r0 && r1) ? ~mdl_last : r1;
        w[1]    = (r0 && r1) ? 1'b0 : r1;
        mdl_last = w[0];
        tmo_hit = !(ack_after >= 1 && ack_after <= TMO);
        n       = tmo_hit ? TMO : ack_after;
        m0_req  = r0;
        m1_req  = r1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            s_ack   = (i == ack_after);
            s_rdata = rd;
            #1;
            for (int d = 0; d < 2; d++) begin
                chk_bus({t, "_busy"}, d, w[d], 1'b1);
                chk_resp({t, "_busy"}, d, w[d], s_ack, 1'b0, rd, rd);
            end
        end
        @(negedge clk);
        s_ack   = 1'b0;
        s_rdata = $urandom;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        if (tmo_hit) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                chk_bus({t, "_err"}, d, w[d], 1'b0);
                chk_resp({t, "_err"}, d, w[d], 1'b1, 1'b1, 32'hDEAD_BEEF, s_rdata);
            end
            mdl_tmo = (mdl_tmo >= 255) ? 255 : mdl_tmo + 1;
            @(negedge clk);
        end
        // IDLE: a stray slave ack must not reach any master.
        s_ack = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_bus({t, "_idle"}, d, 1'b0, 1'b0);
            chk_resp({t, "_idle"}, d, 1'b0, 1'b0, 1'b0, s_rdata, s_rdata);
            chk_tmo({t, "_idle"}, d);
        end
        s_ack = 1'b0;
    endtask

    task automatic chk_reset(input string t);
        obs_t o;
        for (int d = 0; d < 2; d++) begin
            o = sample(d);
            chk(pfx({t, "_s_cyc"}, d), 32'(o.s_cyc), 32'd0);
            chk(pfx({t, "_grant"}, d), 32'(o.grant), 32'd0);
            chk(pfx({t, "_tmo"}, d), 32'(o.tmo), 32'd0);
            chk_resp(t, d, 1'b0, 1'b0, 1'b0, s_rdata, s_rdata);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        bit r0, r1;
        int aa;

        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0; s_rdata = 32'h0BAD_F00D;
        set_m(0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_m(1, 32'h0, 1'b0, 32'h0, 4'h0);
        mdl_last = 1'b1;
        mdl_tmo  = 0;

        repeat (2) @(negedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // m0 read, slave answers in the third BUSY cycle.
        set_m(0, 32'h0000_0010, 1'b0, 32'h0, 4'hF);
        round("t1", 1'b1, 1'b0, 3, 32'h1234_5678);

        // Both masters requesting every round from reset.
        set_m(0, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
        set_m(1, 32'h0000_0200, 1'b1, 32'hCAFE_0001, 4'hC);
        for (int k = 0; k < 4; k++) round("t2", 1'b1, 1'b1, 1, $urandom);

        // m1 partial write; m0 idle.
        set_m(1, 32'h4000_0000, 1'b1, 32'hAA55_AA55, 4'b0011);
        round("t3", 1'b0, 1'b1, 2, $urandom);

        // Slave never answers m0; m1 is served normally afterwards.
        set_m(0, 32'h2000_0004, 1'b0, 32'h0, 4'hF);
        round("t4", 1'b1, 1'b0, 0, $urandom);
        set_m(1, 32'h2000_0008, 1'b0, 32'h0, 4'hF);
        round("t4b", 1'b0, 1'b1, 1, 32'h5555_0000);

        // Slave ack lands on the last watchdog cycle.
        round("t5", 1'b1, 1'b0, TMO, 32'h0F0F_0F0F);

        // Reset pulse while a transfer is in flight.
        set_m(0, 32'h0000_0040, 1'b0, 32'h0, 4'hF);
        m0_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk_bus("t6_pre", d, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk_reset("t6_rst");
        m0_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mdl_last = 1'b1;
        mdl_tmo  = 0;
        @(negedge clk);
        #1;
        chk_reset("t6_after");
        set_m(1, 32'h0000_0080, 1'b1, 32'h1357_9BDF, 4'hF);
        round("t6_tie", 1'b1, 1'b1, 1, $urandom);

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            set_m(0, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            set_m(1, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            aa = $urandom_range(1, TMO + 2);
            if (aa > TMO) aa = 0;
            round("rnd", r0, r1, aa, $urandom);
        end

        // Enough timeouts to drive the counter into saturation.
        for (int k = 0; k < 256; k++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = ~r0;
            round("sat", r0, r1, 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
